// File: rtl/cordic_ser_pkg.sv
// Shared types and beat-count constants for the CORDIC output serializer.
// CORDIC_SER_CHKSUM_EN adds one XOR checksum beat to every frame.
package cordic_ser_pkg;

    localparam int DATA_W_DEF     = 56;
    localparam int SER_W_DEF      = 8;
    localparam int NUM_DATA_BEATS = DATA_W_DEF / SER_W_DEF;

`ifdef CORDIC_SER_CHKSUM_EN
    localparam int NUM_BEATS = NUM_DATA_BEATS + 1;
`else
    localparam int NUM_BEATS = NUM_DATA_BEATS;
`endif

    localparam int BEAT_CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } e_ser_state;

    typedef struct packed {
        logic                 vld;
        logic                 sof;
        logic                 eof;
        logic [SER_W_DEF-1:0] data;
    } st_ser_beat;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// Head word is visible combinationally on o_data; the consumer registers it.
module sync_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_async_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_cnt     = r_wr_ptr - r_rd_ptr;
    assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/cordic_out_serializer.sv
// Buffers CORDIC result words and streams them MSB-chunk first as SER_WIDTH beats.
// Define CORDIC_SER_CHKSUM_EN to append an XOR checksum beat to each frame.
module cordic_out_serializer
    import cordic_ser_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int SER_WIDTH  = SER_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_async_rst_n,
    input  logic                          i_vld,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_clr_ovf,
    output logic                          o_ser_vld,
    output logic [SER_WIDTH-1:0]          o_ser_data,
    output logic                          o_ser_sof,
    output logic                          o_ser_eof,
    input  logic                          i_ser_rdy,
    output logic                          o_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_last;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_fifo_dout;

    e_ser_state            r_state;
    e_ser_state            w_state_next;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] w_shreg_next;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [BEAT_CNT_W-1:0] w_beat_cnt_next;
    logic                  r_ovf;
    st_ser_beat            w_beat;

    assign w_last   = (r_beat_cnt == BEAT_CNT_W'(NUM_BEATS - 1));
    assign w_accept = (r_state == SEND) && i_ser_rdy;
    // Pop when idle, or on acceptance of the final beat so frames run back to back.
    assign w_pop    = !w_empty && ((r_state == IDLE) || (w_accept && w_last));
    assign w_push   = i_vld && (!w_full || w_pop);
    assign w_drop   = i_vld && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk         (i_clk),
        .i_async_rst_n (i_async_rst_n),
        .i_push        (w_push),
        .i_data        (i_data),
        .i_pop         (w_pop),
        .o_data        (w_fifo_dout),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_cnt         (o_fifo_cnt)
    );

    always_comb begin
        w_state_next    = r_state;
        w_shreg_next    = r_shreg;
        w_beat_cnt_next = r_beat_cnt;
        if (w_pop) begin
            w_state_next    = SEND;
            w_shreg_next    = w_fifo_dout;
            w_beat_cnt_next = '0;
        end else if (w_accept) begin
            if (w_last) begin
                w_state_next = IDLE;
            end else begin
                w_shreg_next    = r_shreg << SER_WIDTH;
                w_beat_cnt_next = r_beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_beat_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shreg    <= w_shreg_next;
            r_beat_cnt <= w_beat_cnt_next;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef CORDIC_SER_CHKSUM_EN
    logic [SER_WIDTH-1:0] w_chk;
    logic [SER_WIDTH-1:0] r_chk;

    always_comb begin
        w_chk = '0;
        for (int i = 0; i < DATA_WIDTH / SER_WIDTH; i++) begin
            w_chk = w_chk ^ w_fifo_dout[i*SER_WIDTH +: SER_WIDTH];
        end
    end

    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            r_chk <= '0;
        end else if (w_pop) begin
            r_chk <= w_chk;
        end
    end
`endif

    always_comb begin
        w_beat = '0;
        if (r_state == SEND) begin
            w_beat.vld  = 1'b1;
            w_beat.sof  = (r_beat_cnt == '0);
            w_beat.eof  = w_last;
            w_beat.data = r_shreg[DATA_WIDTH-1 -: SER_WIDTH];
`ifdef CORDIC_SER_CHKSUM_EN
            if (r_beat_cnt == BEAT_CNT_W'(NUM_DATA_BEATS)) begin
                w_beat.data = r_chk;
            end
`endif
        end
    end

    assign o_ser_vld  = w_beat.vld;
    assign o_ser_sof  = w_beat.sof;
    assign o_ser_eof  = w_beat.eof;
    assign o_ser_data = w_beat.data;
    assign o_ovf      = r_ovf;

endmodule
